// File: rtl/br_arb_rr_packet_lock_if.sv
// -----------------------------------------------------------------------------
// br_arb_rr_packet_lock_if
// Bundles the requester side and the downstream side of the packet arbiter.
//
// Handshake: a beat moves downstream on a rising clk edge when out_valid and
// out_ready are both high. request[i] is requester i's valid. grant/out_valid
// are combinational from request and arbiter state. out_ready may depend on
// out_valid, but out_valid never depends on out_ready.
//
// Signals:
//   request       [N]  per-requester valid
//   request_last  [N]  current beat of requester i ends its packet
//   out_ready     [1]  downstream ready
//   grant         [N]  one-hot (or zero) grant
//   out_valid     [1]  |grant
//
// Modports:
//   slave  - the arbiter (consumes requests, drives grant)
//   master - requesters plus downstream sink (drives requests and ready)
// -----------------------------------------------------------------------------
interface br_arb_rr_packet_lock_if #(
   parameter int NumRequesters = 2
);
   logic [NumRequesters-1:0] request;
   logic [NumRequesters-1:0] request_last;
   logic                     out_ready;
   logic [NumRequesters-1:0] grant;
   logic                     out_valid;

   modport slave (
      input  request,
      input  request_last,
      input  out_ready,
      output grant,
      output out_valid
   );

   modport master (
      output request,
      output request_last,
      output out_ready,
      input  grant,
      input  out_valid
   );
endinterface

// File: rtl/br_arb_rr_packet_lock.sv
// -----------------------------------------------------------------------------
// br_arb_rr_packet_lock
// Round-robin packet arbiter with grant locking. A round-robin pointer
// (last_grant) builds a thermometer priority mask. Requesters above the last
// winner are preferred. Once a non-last beat is accepted, the grant is locked
// to that requester until its last beat is accepted, so packets never
// interleave.
//
// Ports:
//   clk                     clock, rising edge
//   rst_n                   asynchronous active-low reset
//   bus (slave modport)     request / request_last / out_ready in,
//                           grant / out_valid out (combinational)
//   enable_priority_update  low freezes the round-robin pointer
//   locked                  registered, high while a packet is in progress
//   protocol_error          registered sticky flag: the locked requester
//                           dropped its request mid-packet
//   dbg_state               FSM state (0 = IDLE, 1 = LOCKED)
//   dbg_last_grant          round-robin pointer (one-hot)
// -----------------------------------------------------------------------------
module br_arb_rr_packet_lock #(
   parameter int NumRequesters = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   br_arb_rr_packet_lock_if.slave   bus,
   input  logic                     enable_priority_update,
   output logic                     locked,
   output logic                     protocol_error,
   output logic                     dbg_state,
   output logic [NumRequesters-1:0] dbg_last_grant
);

   localparam int N    = NumRequesters;
   localparam int IdxW = (N > 1) ? $clog2(N) : 1;

   if (NumRequesters < 2) begin : g_bad_param
      $error("br_arb_rr_packet_lock: NumRequesters must be >= 2");
   end

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] locked_idx_q, locked_idx_d;
   logic [N-1:0]    last_grant_q, last_grant_d;
   logic            locked_q, locked_d;
   logic            perr_q, perr_d;

   logic [N-1:0]    pm;
   logic [N-1:0]    hi;
   logic [N-1:0]    arb_src;
   logic [N-1:0]    arb_pick;
   logic [N-1:0]    lock_oh;
   logic [N-1:0]    grant_c;
   logic [IdxW-1:0] grant_idx;
   logic            acc;
   logic            last_beat;

   // Thermometer mask: pm[i] is set when the last winner sits at or above i.
   // Masking those out leaves the requesters strictly above the last winner.
   always_comb begin
      pm        = '0;
      pm[N-1]   = last_grant_q[N-1];
      for (int i = N - 2; i >= 0; i--) begin
         pm[i] = pm[i+1] | last_grant_q[i];
      end
   end

   always_comb begin
      hi      = bus.request & ~pm;
      arb_src = (|hi) ? hi : bus.request;
      // Scan downward so the final assignment is the lowest set bit.
      arb_pick = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (arb_src[i]) begin
            arb_pick    = '0;
            arb_pick[i] = 1'b1;
         end
      end
   end

   always_comb begin
      lock_oh               = '0;
      lock_oh[locked_idx_q] = 1'b1;
   end

   // While locked, the mask is ignored and only the owner can be granted.
   assign grant_c = (state_q == ST_LOCKED) ? (lock_oh & bus.request) : arb_pick;

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_c[i]) grant_idx = IdxW'(i);
      end
   end

   assign acc       = (|grant_c) & bus.out_ready;
   assign last_beat = bus.request_last[grant_idx];

   always_comb begin
      state_d      = state_q;
      locked_idx_d = locked_idx_q;
      last_grant_d = last_grant_q;
      perr_d       = perr_q;

      if (state_q == ST_IDLE) begin
         if (acc && !last_beat) begin
            state_d      = ST_LOCKED;
            locked_idx_d = grant_idx;
         end
      end else begin
         if (acc && last_beat) begin
            state_d = ST_IDLE;
         end
         // The owner's request is low while locked. This also catches a beat
         // that was offered, left unaccepted, and then withdrawn.
         if (!bus.request[locked_idx_q]) begin
            perr_d = 1'b1;
         end
      end

      // The pointer moves only when a packet completes.
      if (acc && last_beat && enable_priority_update) begin
         last_grant_d = grant_c;
      end

      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         locked_idx_q <= '0;
         last_grant_q <= {1'b1, {(N-1){1'b0}}};
         locked_q     <= 1'b0;
         perr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         locked_idx_q <= locked_idx_d;
         last_grant_q <= last_grant_d;
         locked_q     <= locked_d;
         perr_q       <= perr_d;
      end
   end

   assign bus.grant      = grant_c;
   assign bus.out_valid  = |grant_c;
   assign locked         = locked_q;
   assign protocol_error = perr_q;
   assign dbg_state      = state_q;
   assign dbg_last_grant = last_grant_q;

   a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(grant_c));
   a_last_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot(last_grant_q));
   a_lock_subset : assert property (@(posedge clk) disable iff (!rst_n)
      locked_q |-> ((grant_c & ~lock_oh) == '0));
   a_pm_thermo : assert property (@(posedge clk) disable iff (!rst_n)
      pm[0] && (((pm >> 1) & ~pm) == '0));

endmodule

// File: tb/tb_br_arb_rr_packet_lock.sv
// -----------------------------------------------------------------------------
// tb_br_arb_rr_packet_lock
// Directed bench for the round-robin packet arbiter with N = 4.
// -----------------------------------------------------------------------------
module tb_br_arb_rr_packet_lock;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         enable_priority_update;
   logic         locked;
   logic         protocol_error;
   logic         dbg_state;
   logic [N-1:0] dbg_last_grant;

   int checks   = 0;
   int failures = 0;

   br_arb_rr_packet_lock_if #(.NumRequesters(N)) bus ();

   br_arb_rr_packet_lock #(.NumRequesters(N)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .bus                    (bus),
      .enable_priority_update (enable_priority_update),
      .locked                 (locked),
      .protocol_error         (protocol_error),
      .dbg_state              (dbg_state),
      .dbg_last_grant         (dbg_last_grant)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   // Advance to 2 time units after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [N-1:0] req, input logic [N-1:0] last,
                        input logic rdy);
      bus.request      = req;
      bus.request_last = last;
      bus.out_ready    = rdy;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [N-1:0] obs,
                      input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   logic [N-1:0] seq1 [5];

   initial begin
      seq1[0] = 4'b0001;
      seq1[1] = 4'b0010;
      seq1[2] = 4'b0100;
      seq1[3] = 4'b1000;
      seq1[4] = 4'b0001;

      enable_priority_update = 1'b1;
      bus.request      = '0;
      bus.request_last = '0;
      bus.out_ready    = 1'b0;
      rst_n            = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #2;
      drive(4'b0000, 4'b0000, 1'b0);
      chk("rst_grant", bus.grant, 4'b0000);
      chk("rst_valid", bus.out_valid, 4'b0000);
      chk("rst_locked", locked, 4'b0000);
      chk("rst_perr", protocol_error, 4'b0000);
      chk("rst_last_grant", dbg_last_grant, 4'b1000);
      chk("rst_state", dbg_state, 4'b0000);
      rst_n = 1'b1;

      // Test 1: all requesters, single-beat packets, rotation without bubbles
      for (int k = 0; k < 5; k++) begin
         drive(4'b1111, 4'b1111, 1'b1);
         chk("t1_grant", bus.grant, seq1[k]);
         chk("t1_locked", locked, 4'b0000);
         tick();
      end
      chk("t1_last_grant", dbg_last_grant, 4'b0001);

      // Test 2: 3-beat packet from req0, then req2 wins
      do_reset();
      drive(4'b0101, 4'b0000, 1'b1);
      chk("t2_b1_grant", bus.grant, 4'b0001);
      chk("t2_b1_locked", locked, 4'b0000);
      tick();
      drive(4'b0101, 4'b0000, 1'b1);
      chk("t2_b2_grant", bus.grant, 4'b0001);
      chk("t2_b2_locked", locked, 4'b0001);
      chk("t2_b2_last_grant", dbg_last_grant, 4'b1000);
      tick();
      drive(4'b0101, 4'b0001, 1'b1);
      chk("t2_b3_grant", bus.grant, 4'b0001);
      chk("t2_b3_locked", locked, 4'b0001);
      tick();
      drive(4'b0101, 4'b0100, 1'b1);
      chk("t2_c4_grant", bus.grant, 4'b0100);
      chk("t2_c4_locked", locked, 4'b0000);
      chk("t2_c4_last_grant", dbg_last_grant, 4'b0001);
      chk("t2_c4_valid", bus.out_valid, 4'b0001);
      tick();
      chk("t2_after_last_grant", dbg_last_grant, 4'b0100);

      // Test 3: locked on req2, out_ready low for 5 cycles with contenders
      do_reset();
      drive(4'b0100, 4'b0000, 1'b1);
      chk("t3_start_grant", bus.grant, 4'b0100);
      tick();
      for (int k = 0; k < 5; k++) begin
         drive(4'b1110, 4'b0000, 1'b0);
         chk("t3_stall_grant", bus.grant, 4'b0100);
         chk("t3_stall_locked", locked, 4'b0001);
         chk("t3_stall_state", dbg_state, 4'b0001);
         chk("t3_stall_last_grant", dbg_last_grant, 4'b1000);
         tick();
      end
      drive(4'b1110, 4'b0100, 1'b1);
      chk("t3_last_grant_beat", bus.grant, 4'b0100);
      tick();
      drive(4'b1010, 4'b1010, 1'b1);
      chk("t3_next_grant", bus.grant, 4'b1000);
      chk("t3_next_locked", locked, 4'b0000);
      chk("t3_next_last_grant", dbg_last_grant, 4'b0100);
      tick();

      // Test 4: pointer frozen
      do_reset();
      enable_priority_update = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(4'b0011, 4'b0011, 1'b1);
         chk("t4_grant", bus.grant, 4'b0001);
         chk("t4_last_grant", dbg_last_grant, 4'b1000);
         tick();
      end
      enable_priority_update = 1'b1;

      // Test 5: locked requester withdraws -> sticky protocol_error
      do_reset();
      drive(4'b0010, 4'b0000, 1'b1);
      chk("t5_start_grant", bus.grant, 4'b0010);
      tick();
      drive(4'b0101, 4'b0000, 1'b1);
      chk("t5_drop_grant", bus.grant, 4'b0000);
      chk("t5_drop_valid", bus.out_valid, 4'b0000);
      chk("t5_drop_locked", locked, 4'b0001);
      chk("t5_drop_perr", protocol_error, 4'b0000);
      tick();
      drive(4'b0101, 4'b0000, 1'b1);
      chk("t5_err_perr", protocol_error, 4'b0001);
      chk("t5_err_grant", bus.grant, 4'b0000);
      chk("t5_err_locked", locked, 4'b0001);
      tick();
      drive(4'b0111, 4'b0010, 1'b1);
      chk("t5_resume_grant", bus.grant, 4'b0010);
      chk("t5_resume_perr", protocol_error, 4'b0001);
      tick();
      drive(4'b0000, 4'b0000, 1'b0);
      chk("t5_sticky_perr", protocol_error, 4'b0001);
      chk("t5_sticky_locked", locked, 4'b0000);
      tick();
      rst_n = 1'b0;
      #1;
      chk("t5_rst_perr", protocol_error, 4'b0000);
      chk("t5_rst_locked", locked, 4'b0000);
      chk("t5_rst_last_grant", dbg_last_grant, 4'b1000);
      rst_n = 1'b1;

      // Test 6: reset asserted mid-packet
      drive(4'b1000, 4'b0000, 1'b1);
      chk("t6_start_grant", bus.grant, 4'b1000);
      tick();
      drive(4'b1000, 4'b0000, 1'b1);
      chk("t6_locked", locked, 4'b0001);
      rst_n = 1'b0;
      #1;
      chk("t6_async_locked", locked, 4'b0000);
      chk("t6_async_state", dbg_state, 4'b0000);
      chk("t6_async_perr", protocol_error, 4'b0000);
      tick();
      rst_n = 1'b1;
      drive(4'b1001, 4'b1001, 1'b1);
      chk("t6_after_grant", bus.grant, 4'b0001);
      chk("t6_after_locked", locked, 4'b0000);
      chk("t6_after_last_grant", dbg_last_grant, 4'b1000);
      tick();

      // ---------------- final report ----------------
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
